// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - next-state generator with 2-entry micro-return stack
module microsequencer #(
  parameter int MAX_STATE = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic       inv,
  input  logic [2:0] cond_sel,
  input  logic [9:0] cr,
  input  logic [9:0] enc_addr,
  input  logic       mfc,
  input  logic       cond_pass,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       flag_c,
  input  logic       flag_v,
  output logic [9:0] next_state,
  output logic       illegal_state,
  output logic       stack_err
);

  localparam logic [9:0] LIMIT = 10'(MAX_STATE);

  logic       sel_cond;
  logic       c;
  logic [9:0] inc;
  logic [9:0] target;
  logic       out_of_range;
  logic       is_call;
  logic       is_ret;
  logic [9:0] stk_top;
  logic [9:0] stk_bot;
  logic [1:0] stk_cnt;

  // Raw condition selected by cond_sel
  always_comb begin
    sel_cond = 1'b0;
    case (cond_sel)
      3'b000:  sel_cond = mfc;
      3'b001:  sel_cond = cond_pass;
      3'b010:  sel_cond = flag_z;
      3'b011:  sel_cond = flag_n;
      3'b100:  sel_cond = flag_c;
      3'b101:  sel_cond = flag_v;
      3'b110:  sel_cond = 1'b0;
      default: sel_cond = 1'b1;
    endcase
  end

  // In mode 111 inv picks call/return, so it must not flip the condition
  assign c       = (mode == 3'b111) ? sel_cond : (sel_cond ^ inv);
  assign inc     = next_state + 10'd1;
  assign is_call = (mode == 3'b111) && !inv;
  assign is_ret  = (mode == 3'b111) && inv;

  // Target selection; an empty-stack return yields state 0
  always_comb begin
    target = '0;
    case (mode)
      3'b000:  target = enc_addr;
      3'b001:  target = '0;
      3'b010:  target = cr;
      3'b011:  target = inc;
      3'b100:  target = c ? cr : inc;
      3'b101:  target = c ? cr : enc_addr;
      3'b110:  target = c ? inc : cr;
      default: target = is_call ? cr : ((stk_cnt == 2'd0) ? 10'd0 : stk_top);
    endcase
  end

  assign out_of_range = (target > LIMIT);

  // Register next state, range flag and return stack on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_state    <= '0;
      illegal_state <= 1'b0;
      stack_err     <= 1'b0;
      stk_top       <= '0;
      stk_bot       <= '0;
      stk_cnt       <= '0;
    end else begin
      next_state    <= out_of_range ? 10'd0 : target;
      illegal_state <= out_of_range;
      if (is_call) begin
        // A push on a full stack drops the older entry
        stk_bot <= stk_top;
        stk_top <= inc;
        if (stk_cnt == 2'd2) begin
          stack_err <= 1'b1;
        end else begin
          stk_cnt <= stk_cnt + 2'd1;
        end
      end else if (is_ret) begin
        if (stk_cnt == 2'd0) begin
          stack_err <= 1'b1;
        end else begin
          stk_top <= stk_bot;
          stk_bot <= '0;
          stk_cnt <= stk_cnt - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - scoreboard bench for microsequencer
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] mode = '0;
  logic       inv = 1'b0;
  logic [2:0] cond_sel = '0;
  logic [9:0] cr = '0;
  logic [9:0] enc_addr = '0;
  logic       mfc = 1'b0;
  logic       cond_pass = 1'b0;
  logic       flag_z = 1'b0;
  logic       flag_n = 1'b0;
  logic       flag_c = 1'b0;
  logic       flag_v = 1'b0;
  logic [9:0] next_state;
  logic       illegal_state;
  logic       stack_err;

  typedef struct {
    logic [9:0] ns;
    logic       ill;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  microsequencer #(.MAX_STATE(256)) dut (
    .clk(clk), .reset(reset), .mode(mode), .inv(inv), .cond_sel(cond_sel),
    .cr(cr), .enc_addr(enc_addr), .mfc(mfc), .cond_pass(cond_pass),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .next_state(next_state), .illegal_state(illegal_state), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one microinstruction, queue its expected result, clock, then compare
  task automatic step(input string tag, input logic [2:0] m, input logic i,
                      input logic [2:0] cs, input logic [9:0] c_lit, input logic [9:0] ea,
                      input logic [9:0] e_ns, input logic e_ill, input logic e_err);
    exp_t e;
    exp_t o;
    mode = m; inv = i; cond_sel = cs; cr = c_lit; enc_addr = ea;
    e.ns = e_ns; e.ill = e_ill; e.err = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    check({tag, ".ns"}, 32'(next_state), 32'(o.ns));
    check({tag, ".ill"}, 32'(illegal_state), 32'(o.ill));
    check({tag, ".err"}, 32'(stack_err), 32'(o.err));
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, ".ns"}, 32'(next_state), 32'd0);
    check({tag, ".ill"}, 32'(illegal_state), 32'd0);
    check({tag, ".err"}, 32'(stack_err), 32'd0);
    #2 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst.ns", 32'(next_state), 32'd0);
    check("rst.ill", 32'(illegal_state), 32'd0);
    check("rst.err", 32'(stack_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Mid-cycle reset at state 37, then increment from 0
    step("jmp37", 3'b010, 0, 3'd0, 10'd37, 10'd0, 10'd37, 0, 0);
    pulse_reset("midrst");
    step("inc0", 3'b011, 0, 3'd0, 10'd0, 10'd0, 10'd1, 0, 0);

    // Wait loop on mfc
    step("jmp5", 3'b010, 0, 3'd0, 10'd5, 10'd0, 10'd5, 0, 0);
    mfc = 1'b0;
    for (int k = 0; k < 3; k++) step("wait", 3'b110, 0, 3'd0, 10'd5, 10'd0, 10'd5, 0, 0);
    mfc = 1'b1;
    step("waitdone", 3'b110, 0, 3'd0, 10'd5, 10'd0, 10'd6, 0, 0);
    mfc = 1'b0;

    // Dispatch and conditional branches
    step("disp", 3'b000, 0, 3'd0, 10'd0, 10'd20, 10'd20, 0, 0);
    flag_z = 1'b1;
    step("brz", 3'b100, 0, 3'd2, 10'd42, 10'd0, 10'd42, 0, 0);
    step("brnz", 3'b100, 1, 3'd2, 10'd42, 10'd0, 10'd43, 0, 0);
    flag_z = 1'b0;
    step("c1disp", 3'b101, 0, 3'd7, 10'd77, 10'd88, 10'd77, 0, 0);
    step("c0disp", 3'b101, 0, 3'd6, 10'd77, 10'd88, 10'd88, 0, 0);
    step("fetch", 3'b001, 0, 3'd0, 10'd99, 10'd99, 10'd0, 0, 0);

    // Nested call/return and underflow
    step("jmp100", 3'b010, 0, 3'd0, 10'd100, 10'd0, 10'd100, 0, 0);
    step("call200", 3'b111, 0, 3'd0, 10'd200, 10'd0, 10'd200, 0, 0);
    step("call210", 3'b111, 0, 3'd0, 10'd210, 10'd0, 10'd210, 0, 0);
    step("ret1", 3'b111, 1, 3'd0, 10'd0, 10'd0, 10'd201, 0, 0);
    step("ret2", 3'b111, 1, 3'd0, 10'd0, 10'd0, 10'd101, 0, 0);
    step("ret_uf", 3'b111, 1, 3'd0, 10'd0, 10'd0, 10'd0, 0, 1);
    pulse_reset("rst2");

    // Overflow: three nested calls keep the two newest returns
    step("jmp10", 3'b010, 0, 3'd0, 10'd10, 10'd0, 10'd10, 0, 0);
    step("ocall20", 3'b111, 0, 3'd0, 10'd20, 10'd0, 10'd20, 0, 0);
    step("ocall30", 3'b111, 0, 3'd0, 10'd30, 10'd0, 10'd30, 0, 0);
    step("ocall40", 3'b111, 0, 3'd0, 10'd40, 10'd0, 10'd40, 0, 1);
    step("oret31", 3'b111, 1, 3'd0, 10'd0, 10'd0, 10'd31, 0, 1);
    step("oret21", 3'b111, 1, 3'd0, 10'd0, 10'd0, 10'd21, 0, 1);
    step("oret0", 3'b111, 1, 3'd0, 10'd0, 10'd0, 10'd0, 0, 1);
    pulse_reset("rst3");

    // Range checks
    step("jmp300", 3'b010, 0, 3'd0, 10'd300, 10'd0, 10'd0, 1, 0);
    step("after300", 3'b011, 0, 3'd0, 10'd0, 10'd0, 10'd1, 0, 0);
    step("jmp256", 3'b010, 0, 3'd0, 10'd256, 10'd0, 10'd256, 0, 0);
    step("inc257", 3'b011, 0, 3'd0, 10'd0, 10'd0, 10'd0, 1, 0);
    step("inc1", 3'b011, 0, 3'd0, 10'd0, 10'd0, 10'd1, 0, 0);
    step("badcall", 3'b111, 0, 3'd0, 10'd300, 10'd0, 10'd0, 1, 0);
    step("retbad", 3'b111, 1, 3'd0, 10'd0, 10'd0, 10'd2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state generator for the microprogrammed control unit. Each cycle it takes the sequencing fields of the control word currently selected from the microstore, the instruction decoder's dispatch address and the status conditions, and registers the 10-bit state number that the microstore decodes next. It also holds a 2-entry micro-return stack so microcode can share subroutines. It closes the loop: microstore word → microsequencer → `next_state` → microstore.

## Interface
- `MAX_STATE`, 256: highest populated microstore state.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mode` in 3: next-state mode field of the current control word.
- `inv` in 1: condition invert bit; selects call or return in mode 111.
- `cond_sel` in 3: condition select field.
- `cr` in 10: control-register literal (jump target).
- `enc_addr` in 10: dispatch address from the instruction decoder.
- `mfc` in 1: memory function complete.
- `cond_pass` in 1: instruction condition-tester result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v` in 1 each: status flags.
- `next_state` out 10: registered state number to the microstore.
- `illegal_state` out 1: one-cycle pulse when a computed target exceeds `MAX_STATE`.
- `stack_err` out 1: sticky flag for return-stack overflow or underflow. Cleared only by reset.

## Operation
- Condition `c` is selected by `cond_sel`, then XORed with `inv`, except in mode 111 where `inv` has no effect on `c`.
  - 000 `mfc`
  - 001 `cond_pass`
  - 010 `flag_z`
  - 011 `flag_n`
  - 100 `flag_c`
  - 101 `flag_v`
  - 110 constant 0
  - 111 constant 1
- `inc` = `next_state` + 1, modulo 1024 (1023 wraps to 0).
- Target selection by `mode`:
  - 000 `enc_addr` (dispatch).
  - 001 state 0 (fetch).
  - 010 `cr`.
  - 011 `inc`.
  - 100 `c` ? `cr` : `inc`.
  - 101 `c` ? `cr` : `enc_addr`.
  - 110 `c` ? `inc` : `cr` (wait loop; `cr` normally equals the current state).
  - 111 with `inv`=0 is a call: push `inc`, target `cr`.
  - 111 with `inv`=1 is a return: pop, target is the popped value.
- Return stack:
  - 2 entries plus a 2-bit count.
  - Push while count=2: the older entry is discarded, the new entry goes on top, count stays 2, and `stack_err` is set.
  - Pop while count=0: the target is 0, count stays 0, and `stack_err` is set.
- Range check: if the selected target is greater than `MAX_STATE`, the register loads 0 instead and `illegal_state` is 1 for that cycle. A stack push still occurs on an illegal call.
- Reset (low, asynchronous, takes effect at any point, including mid-wait or mid-call):
  - `next_state` = 0
  - stack count = 0, entries = 0
  - `illegal_state` = 0, `stack_err` = 0
  - The first rising edge after reset deasserts evaluates the state-0 word.

## Timing
- All inputs are sampled at the rising edge. The new `next_state` is visible immediately after that edge.
- Latency is one cycle per microinstruction; there is no stall input. Waiting is expressed only with mode 110.
- `illegal_state` is registered and aligns with the cycle in which `next_state` = 0 because of the range check.
- In mode 111, the stack update and the `next_state` update happen on the same edge.
- A call immediately followed by a return comes back to the call site + 1 with no bubble.

## Test plan
- **Reset:** pulse `reset` low mid-cycle while `next_state`=37.
  - `next_state`=0 asynchronously, flags 0.
  - First edge with `mode`=011 gives 1.
- **Wait loop:** `mode`=110, `cond_sel`=000, `cr`=5, `next_state`=5, `mfc`=0 for 3 edges, then 1.
  - `next_state` holds at 5 for 3 cycles, then 6.
- **Dispatch and conditional:**
  - `mode`=000, `enc_addr`=20 → 20.
  - `mode`=100, `cond_sel`=010, `flag_z`=1, `cr`=42 → 42.
  - Same with `inv`=1 → `inc`.
- **Call/return:** at state 100, call `cr`=200, then at 200 call `cr`=210, then return twice.
  - Sequence is 200, 210, 201, 101.
  - A third return gives 0 and sets `stack_err`.
- **Overflow:** three nested calls from states 10, 20, 30.
  - `stack_err`=1.
  - Two returns give 31, then 21.
- **Range/wrap:**
  - `mode`=010, `cr`=300 → `next_state`=0 with a one-cycle `illegal_state`.
  - `next_state`=256 with `mode`=011 → 257 exceeds `MAX_STATE` → 0 with `illegal_state`.
